// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: run enable and colour in,
// raster coordinates, sync, data-enable, strobes and registered colour out.
interface vga_timing_gen_if #(
    parameter int HW = 10,
    parameter int VW = 10,
    parameter int RW = 3,
    parameter int GW = 3,
    parameter int BW = 2
);
    logic          en;
    logic [RW-1:0] rin;
    logic [GW-1:0] gin;
    logic [BW-1:0] bin;
    logic [HW-1:0] xpos;
    logic [VW-1:0] ypos;
    logic          pix_tick;
    logic [RW-1:0] rout;
    logic [GW-1:0] gout;
    logic [BW-1:0] bout;
    logic          hs;
    logic          vs;
    logic          de;
    logic          frame_start;
    logic          line_start;

    modport master (
        input  en, rin, gin, bin,
        output xpos, ypos, pix_tick, rout, gout, bout,
               hs, vs, de, frame_start, line_start
    );

    modport slave (
        output en, rin, gin, bin,
        input  xpos, ypos, pix_tick, rout, gout, bout,
               hs, vs, de, frame_start, line_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate prescaler, x/y raster
// counters and a registered output stage that keeps colour aligned with sync.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 29,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RW       = 3,
    parameter int GW       = 3,
    parameter int BW       = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW           = $clog2(H_TOTAL);
    localparam int VW           = $clog2(V_TOTAL);
    localparam int PW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    logic [PW-1:0] r_presc;
    logic [HW-1:0] r_xpos;
    logic [VW-1:0] r_ypos;

    logic          w_pix_tick;
    logic          w_x_last;
    logic          w_y_last;
    logic          w_de_next;
    logic          w_hs_pulse;
    logic          w_vs_pulse;
    logic          w_line_start_next;
    logic          w_frame_start_next;

    logic          r_de;
    logic          r_hs;
    logic          r_vs;
    logic          r_frame_start;
    logic          r_line_start;
    logic [RW-1:0] r_rout;
    logic [GW-1:0] r_gout;
    logic [BW-1:0] r_bout;

    // With CLK_DIV = 1 the compare constant is zero and r_presc never leaves it.
    assign w_pix_tick = bus.en && (r_presc == PW'(CLK_DIV - 1));
    assign w_x_last   = (r_xpos == HW'(H_TOTAL - 1));
    assign w_y_last   = (r_ypos == VW'(V_TOTAL - 1));

    assign w_de_next  = (int'(r_xpos) < H_ACTIVE) && (int'(r_ypos) < V_ACTIVE);
    assign w_hs_pulse = (int'(r_xpos) >= H_SYNC_START) && (int'(r_xpos) < H_SYNC_END);
    assign w_vs_pulse = (int'(r_ypos) >= V_SYNC_START) && (int'(r_ypos) < V_SYNC_END);

    assign w_line_start_next  = (r_presc == '0) && (r_xpos == '0);
    assign w_frame_start_next = w_line_start_next && (r_ypos == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments make every register in this process
        // sample pre-edge values, so the x/y carry chain cannot race itself.
        if (!rst_n) begin
            r_presc <= '0;
            r_xpos  <= '0;
            r_ypos  <= '0;
        end else if (!bus.en) begin
            r_presc <= '0;
            r_xpos  <= '0;
            r_ypos  <= '0;
        end else begin
            r_presc <= w_pix_tick ? '0 : r_presc + 1'b1;
            if (w_pix_tick) begin
                if (w_x_last) begin
                    r_xpos <= '0;
                    r_ypos <= w_y_last ? '0 : r_ypos + 1'b1;
                end else begin
                    r_xpos <= r_xpos + 1'b1;
                end
            end
        end
    end

    // Output stage lags the counters by one clk; en low parks it at reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de          <= 1'b0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_rout        <= '0;
            r_gout        <= '0;
            r_bout        <= '0;
        end else if (!bus.en) begin
            r_de          <= 1'b0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_rout        <= '0;
            r_gout        <= '0;
            r_bout        <= '0;
        end else begin
            r_de          <= w_de_next;
            r_hs          <= w_hs_pulse ? HS_POL : ~HS_POL;
            r_vs          <= w_vs_pulse ? VS_POL : ~VS_POL;
            r_frame_start <= w_frame_start_next;
            r_line_start  <= w_line_start_next;
            r_rout        <= w_de_next ? bus.rin : '0;
            r_gout        <= w_de_next ? bus.gin : '0;
            r_bout        <= w_de_next ? bus.bin : '0;
        end
    end

    assign bus.xpos        = r_xpos;
    assign bus.ypos        = r_ypos;
    assign bus.pix_tick    = w_pix_tick;
    assign bus.de          = r_de;
    assign bus.hs          = r_hs;
    assign bus.vs          = r_vs;
    assign bus.frame_start = r_frame_start;
    assign bus.line_start  = r_line_start;
    assign bus.rout        = r_rout;
    assign bus.gout        = r_gout;
    assign bus.bout        = r_bout;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two shrunken-raster instances (CLK_DIV=4 active-low
// sync, CLK_DIV=1 active-high sync) against a raster-arithmetic reference model.
module tb_vga_timing_gen;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int HW  = $clog2(HT);
    localparam int VW  = $clog2(VT);
    localparam int A_D = 4;
    localparam int B_D = 1;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic       tick;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       ls;
        logic [7:0] rgb;
    } obs_t;

    typedef struct {
        int cyc;
        bit en;
        int x;
        int y;
        bit tick, de, hs, vs, fs, ls;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    int   n_a, n_b;
    obs_t reg_a, reg_b;
    bit   cur_en;
    obs_t act_a, act_b;
    vec_t tbl[10];

    vga_timing_gen_if #(.HW(HW), .VW(VW), .RW(3), .GW(3), .BW(2)) if_a ();
    vga_timing_gen_if #(.HW(HW), .VW(VW), .RW(3), .GW(3), .BW(2)) if_b ();

    vga_timing_gen #(
        .CLK_DIV(A_D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .RW(3), .GW(3), .BW(2)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));

    vga_timing_gen #(
        .CLK_DIV(B_D), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .RW(3), .GW(3), .BW(2)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    assign act_a = {8'(if_a.xpos), 8'(if_a.ypos), if_a.pix_tick, if_a.de, if_a.hs, if_a.vs,
                    if_a.frame_start, if_a.line_start, if_a.rout, if_a.gout, if_a.bout};
    assign act_b = {8'(if_b.xpos), 8'(if_b.ypos), if_b.pix_tick, if_b.de, if_b.hs, if_b.vs,
                    if_b.frame_start, if_b.line_start, if_b.rout, if_b.gout, if_b.bout};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered outputs while idle or in reset.
    function automatic obs_t reg_reset(bit hp, bit vp);
        obs_t o = '0;
        o.hs = ~hp;
        o.vs = ~vp;
        return o;
    endfunction

    // Registered outputs produced from raster state n (enabled clks since idle).
    function automatic obs_t reg_decode(int d, bit hp, bit vp, int n, logic [7:0] rgb);
        int   p = n / d;
        int   x = p % HT;
        int   y = (p / HT) % VT;
        obs_t o = '0;
        o.de  = (x < HA) && (y < VA);
        o.hs  = (x >= HA + HFP && x < HA + HFP + HSY) ? hp : ~hp;
        o.vs  = (y >= VA + VFP && y < VA + VFP + VSY) ? vp : ~vp;
        o.ls  = (n % d == 0) && (x == 0);
        o.fs  = o.ls && (y == 0);
        o.rgb = o.de ? rgb : 8'h00;
        return o;
    endfunction

    function automatic obs_t expect_obs(int d, int n, bit en, obs_t regs);
        obs_t o = regs;
        o.x    = 8'((n / d) % HT);
        o.y    = 8'((n / d / HT) % VT);
        o.tick = en && (n % d == d - 1);
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d tick=%0b de=%0b hs=%0b vs=%0b fs=%0b ls=%0b rgb=%02h",
                         o.x, o.y, o.tick, o.de, o.hs, o.vs, o.fs, o.ls, o.rgb);
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic model_reset();
        n_a   = 0;
        n_b   = 0;
        reg_a = reg_reset(1'b0, 1'b0);
        reg_b = reg_reset(1'b1, 1'b1);
    endtask

    // Drive one clk of stimulus from just after a falling edge, then check both DUTs.
    task automatic step(input bit en, input logic [7:0] rgb);
        cur_en   = en;
        if_a.en  = en;
        if_b.en  = en;
        if_a.rin = rgb[7:5];
        if_a.gin = rgb[4:2];
        if_a.bin = rgb[1:0];
        if_b.rin = rgb[7:5];
        if_b.gin = rgb[4:2];
        if_b.bin = rgb[1:0];
        @(posedge clk);
        if (en) begin
            reg_a = reg_decode(A_D, 1'b0, 1'b0, n_a, rgb);
            reg_b = reg_decode(B_D, 1'b1, 1'b1, n_b, rgb);
            n_a   = (n_a + 1) % (A_D * HT * VT);
            n_b   = (n_b + 1) % (B_D * HT * VT);
        end else begin
            model_reset();
        end
        @(negedge clk);
        check("model_a", act_a, expect_obs(A_D, n_a, en, reg_a));
        check("model_b", act_b, expect_obs(B_D, n_b, en, reg_b));
    endtask

    initial begin
        obs_t e;
        logic [7:0] rgb;
        bit en;

        // cyc, en, x, y, tick, de, hs, vs, fs, ls -- instance A, zero colour
        tbl[0] = '{1,  1'b0, 0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1,  1'b1, 0,  0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{1,  1'b1, 0,  0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1,  1'b1, 0,  0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{41, 1'b1, 11, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{20, 1'b1, 0,  1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1,  1'b1, 0,  1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1,  1'b0, 0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{50, 1'b0, 0,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1,  1'b1, 0,  0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        rst_n    = 1'b0;
        cur_en   = 1'b0;
        if_a.en  = 1'b0;
        if_b.en  = 1'b0;
        if_a.rin = '0; if_a.gin = '0; if_a.bin = '0;
        if_b.rin = '0; if_b.gin = '0; if_b.bin = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_a", act_a, expect_obs(A_D, n_a, 1'b0, reg_a));
        check("reset_b", act_b, expect_obs(B_D, n_b, 1'b0, reg_b));
        rst_n = 1'b1;

        // Hand-derived vectors: start-up latency, first tick, h-sync, line wrap, en drop and restart.
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < tbl[i].cyc; k++) step(tbl[i].en, 8'h00);
            e      = '0;
            e.x    = 8'(tbl[i].x);
            e.y    = 8'(tbl[i].y);
            e.tick = tbl[i].tick;
            e.de   = tbl[i].de;
            e.hs   = tbl[i].hs;
            e.vs   = tbl[i].vs;
            e.fs   = tbl[i].fs;
            e.ls   = tbl[i].ls;
            check($sformatf("vec%0d", i), act_a, e);
        end

        // Fixed colour {101,011,10} over whole frames, then random colour with rare en drops.
        for (int k = 0; k < 1500; k++) step(1'b1, 8'b101_011_10);
        for (int k = 0; k < 1500; k++) begin
            en  = ($urandom_range(0, 599) != 0);
            rgb = 8'($urandom);
            step(en, rgb);
        end

        // Asynchronous reset mid-line, released before the next rising edge.
        for (int k = 0; k < 37; k++) step(1'b1, 8'($urandom));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_a", act_a, expect_obs(A_D, n_a, cur_en, reg_a));
        check("async_rst_b", act_b, expect_obs(B_D, n_b, cur_en, reg_b));
        #1 rst_n = 1'b1;
        for (int k = 0; k < 800; k++) step(1'b1, 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
